// File: rtl/miner_pkg.sv
// ----------------------------------------------------------------------------
// miner_pkg
//
// Shared constants for the miner slave register file: bus widths, the word
// address map, CONTROL/STATUS bit positions and the assembled target/message
// widths. Also holds small address-classification helpers that are used by
// both the write decoder and the read mux.
// ----------------------------------------------------------------------------
package miner_pkg;

    // Bus geometry
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    // Assembled vector widths
    localparam int TARGET_W = 256;
    localparam int MSG_W    = 408;

    // Target is 8 full words. The message is 12 full words plus a 24-bit
    // tail that lives in the upper bits of the lowest message word.
    localparam int TGT_WORDS = TARGET_W / DATA_W;
    localparam int MSG_LO_W  = 24;
    localparam int MSG_WORDS = (MSG_W - MSG_LO_W) / DATA_W;

    // Word address map
    localparam logic [ADDR_W-1:0] ADDR_CTRL   = 5'd0;
    localparam logic [ADDR_W-1:0] ADDR_STATUS = 5'd1;
    localparam logic [ADDR_W-1:0] ADDR_NONCE  = 5'd2;
    localparam logic [ADDR_W-1:0] ADDR_MSG_LO = 5'd3;
    localparam logic [ADDR_W-1:0] ADDR_MSG_W0 = 5'd4;   // first full message word
    localparam logic [ADDR_W-1:0] ADDR_MSG_HI = 5'd15;
    localparam logic [ADDR_W-1:0] ADDR_TGT_LO = 5'd16;
    localparam logic [ADDR_W-1:0] ADDR_TGT_HI = 5'd23;

    // CONTROL bit positions (write-only actions)
    localparam int CTRL_NEW_TARGET = 0;
    localparam int CTRL_NEW_MSG    = 1;
    localparam int CTRL_CLEAR      = 2;

    // STATUS bit positions
    localparam int STAT_BUSY  = 0;
    localparam int STAT_FOUND = 1;
    localparam int STAT_DONE  = 2;
    localparam int STAT_ERR   = 3;

    // Address falls in the target window (addr 16..23)
    function automatic logic is_tgt_addr(input logic [ADDR_W-1:0] a);
        return (a >= ADDR_TGT_LO) && (a <= ADDR_TGT_HI);
    endfunction

    // Address is one of the full 32-bit message words (addr 4..15)
    function automatic logic is_msg_word_addr(input logic [ADDR_W-1:0] a);
        return (a >= ADDR_MSG_W0) && (a <= ADDR_MSG_HI);
    endfunction

    // Address is anywhere in the message window, including the tail word
    function automatic logic is_msg_addr(input logic [ADDR_W-1:0] a);
        return (a >= ADDR_MSG_LO) && (a <= ADDR_MSG_HI);
    endfunction

endpackage

// File: rtl/miner_slave_regs_if.sv
// ----------------------------------------------------------------------------
// miner_slave_regs_if
//
// Avalon-MM slave bundle between the bus fabric and the miner register file.
//   slaveAddr        word address
//   slaveWriteData   write data
//   slaveWrite       write request
//   slaveRead        read request
//   slaveChipSelect  qualifies slaveWrite / slaveRead
//   slaveReadData    registered read data (driven by the slave)
// Modports: master (fabric side) and slave (register file side).
// ----------------------------------------------------------------------------
interface miner_slave_regs_if;
    import miner_pkg::*;

    logic [ADDR_W-1:0] slaveAddr;
    logic [DATA_W-1:0] slaveWriteData;
    logic              slaveWrite;
    logic              slaveRead;
    logic              slaveChipSelect;
    logic [DATA_W-1:0] slaveReadData;

    modport master (
        output slaveAddr,
        output slaveWriteData,
        output slaveWrite,
        output slaveRead,
        output slaveChipSelect,
        input  slaveReadData
    );

    modport slave (
        input  slaveAddr,
        input  slaveWriteData,
        input  slaveWrite,
        input  slaveRead,
        input  slaveChipSelect,
        output slaveReadData
    );

endinterface

// File: rtl/miner_slave_regs.sv
// ----------------------------------------------------------------------------
// miner_slave_regs
//
// Host-facing register file for the miner core. Host writes assemble a
// 256-bit target and a 408-bit message from 32-bit words; a CONTROL write
// launches them towards the hashing datapath with single-cycle strobes.
// The core's completion (found flag, winning nonce) is captured into sticky
// status and returned on host reads.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   bus        Avalon-MM slave (miner_slave_regs_if.slave)
//   coreBusy   datapath is hashing; target/message are locked while high
//   coreDone   one-cycle strobe, search finished
//   coreFound  qualifies coreDone: nonce meets target
//   coreNonce  winning nonce, valid with coreDone
//   target     assembled 256-bit target
//   msg        assembled 408-bit message
//   newTarget  one-cycle strobe, target ready
//   newMsg     one-cycle strobe, message ready
// ----------------------------------------------------------------------------
module miner_slave_regs
    import miner_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    miner_slave_regs_if.slave   bus,
    input  logic                coreBusy,
    input  logic                coreDone,
    input  logic                coreFound,
    input  logic [DATA_W-1:0]   coreNonce,
    output logic [TARGET_W-1:0] target,
    output logic [MSG_W-1:0]    msg,
    output logic                newTarget,
    output logic                newMsg
);

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]   tgt_word_reg [TGT_WORDS];
    logic [DATA_W-1:0]   msg_word_reg [MSG_WORDS];
    logic [MSG_LO_W-1:0] msg_lo_reg;

    logic [DATA_W-1:0]   nonce_reg;
    logic [DATA_W-1:0]   nonce_next;
    logic                found_reg;
    logic                found_next;
    logic                done_reg;
    logic                done_next;
    logic                err_reg;
    logic                err_next;

    logic                new_target_reg;
    logic                new_msg_reg;

    logic [DATA_W-1:0]   rd_data_reg;
    logic [DATA_W-1:0]   rd_data_next;

    // ------------------------------------------------------------------
    // Bus qualification and write decode
    // ------------------------------------------------------------------
    logic wr_en;
    logic rd_en;
    logic wr_ctrl;
    logic data_wr_req;     // host tried to write a target/message word
    logic data_wr_ok;      // ... and the datapath is idle, so it lands
    logic req_target;
    logic req_msg;
    logic req_clear;
    logic start_target;
    logic start_msg;
    logic err_set;

    assign wr_en   = bus.slaveChipSelect && bus.slaveWrite;
    assign rd_en   = bus.slaveChipSelect && bus.slaveRead;
    assign wr_ctrl = wr_en && (bus.slaveAddr == ADDR_CTRL);

    assign data_wr_req = wr_en && (is_tgt_addr(bus.slaveAddr) || is_msg_addr(bus.slaveAddr));
    assign data_wr_ok  = data_wr_req && !coreBusy;

    assign req_target = wr_ctrl && bus.slaveWriteData[CTRL_NEW_TARGET];
    assign req_msg    = wr_ctrl && bus.slaveWriteData[CTRL_NEW_MSG];
    assign req_clear  = wr_ctrl && bus.slaveWriteData[CTRL_CLEAR];

    // Launch requests are refused while the core is hashing so that the
    // datapath never sees its operands change mid-search.
    assign start_target = req_target && !coreBusy;
    assign start_msg    = req_msg    && !coreBusy;

    // Any refused data write or launch request flags an error.
    assign err_set = coreBusy && (data_wr_req || req_target || req_msg);

    // Per-word write enables and packing of the word arrays onto the wide
    // outputs. Word 0 of each array is the least significant word.
    logic [TGT_WORDS-1:0] tgt_we;
    logic [MSG_WORDS-1:0] msg_we;
    logic                 msg_lo_we;

    genvar gi;
    generate
        for (gi = 0; gi < TGT_WORDS; gi++) begin : g_tgt
            assign tgt_we[gi] = data_wr_ok && (bus.slaveAddr == ADDR_TGT_LO + ADDR_W'(gi));
            assign target[gi*DATA_W +: DATA_W] = tgt_word_reg[gi];
        end
        for (gi = 0; gi < MSG_WORDS; gi++) begin : g_msg
            assign msg_we[gi] = data_wr_ok && (bus.slaveAddr == ADDR_MSG_W0 + ADDR_W'(gi));
            assign msg[MSG_LO_W + gi*DATA_W +: DATA_W] = msg_word_reg[gi];
        end
    endgenerate

    // The lowest message address carries only 24 message bits in its upper
    // part; the low byte of that bus word is discarded.
    assign msg_lo_we = data_wr_ok && (bus.slaveAddr == ADDR_MSG_LO);
    assign msg[MSG_LO_W-1:0] = msg_lo_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TGT_WORDS; i++) begin
                tgt_word_reg[i] <= '0;
            end
            for (int i = 0; i < MSG_WORDS; i++) begin
                msg_word_reg[i] <= '0;
            end
            msg_lo_reg <= '0;
        end else begin
            for (int i = 0; i < TGT_WORDS; i++) begin
                if (tgt_we[i]) begin
                    tgt_word_reg[i] <= bus.slaveWriteData;
                end
            end
            for (int i = 0; i < MSG_WORDS; i++) begin
                if (msg_we[i]) begin
                    msg_word_reg[i] <= bus.slaveWriteData;
                end
            end
            if (msg_lo_we) begin
                msg_lo_reg <= bus.slaveWriteData[DATA_W-1 -: MSG_LO_W];
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky status and nonce capture
    // ------------------------------------------------------------------
    // Clears are applied first and sets last, so a completion or an error
    // arriving in the same cycle as a clear is never lost.
    always_comb begin
        found_next = found_reg;
        done_next  = done_reg;
        err_next   = err_reg;
        nonce_next = nonce_reg;

        if (req_clear || start_msg) begin
            found_next = 1'b0;
            done_next  = 1'b0;
        end
        if (req_clear) begin
            err_next = 1'b0;
        end

        if (err_set) begin
            err_next = 1'b1;
        end
        if (coreDone) begin
            done_next = 1'b1;
            if (coreFound) begin
                found_next = 1'b1;
                nonce_next = coreNonce;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read mux (registered, one cycle latency; holds when not reading)
    // ------------------------------------------------------------------
    logic [3:0] msg_idx;
    assign msg_idx = bus.slaveAddr[3:0] - ADDR_MSG_W0[3:0];

    always_comb begin
        rd_data_next = '0;
        if (is_tgt_addr(bus.slaveAddr)) begin
            // Target window is 16..23, so the low three bits index the word.
            rd_data_next = tgt_word_reg[bus.slaveAddr[2:0]];
        end else if (is_msg_word_addr(bus.slaveAddr)) begin
            rd_data_next = msg_word_reg[msg_idx];
        end else begin
            case (bus.slaveAddr)
                ADDR_MSG_LO: rd_data_next = {msg_lo_reg, {(DATA_W-MSG_LO_W){1'b0}}};
                ADDR_STATUS: begin
                    rd_data_next[STAT_BUSY]  = coreBusy;
                    rd_data_next[STAT_FOUND] = found_reg;
                    rd_data_next[STAT_DONE]  = done_reg;
                    rd_data_next[STAT_ERR]   = err_reg;
                end
                ADDR_NONCE:  rd_data_next = nonce_reg;
                default:     rd_data_next = '0;   // CONTROL and unmapped
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control/status registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            found_reg      <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
            nonce_reg      <= '0;
            new_target_reg <= 1'b0;
            new_msg_reg    <= 1'b0;
            rd_data_reg    <= '0;
        end else begin
            found_reg      <= found_next;
            done_reg       <= done_next;
            err_reg        <= err_next;
            nonce_reg      <= nonce_next;
            // Strobes are the registered launch decisions, so they are high
            // for exactly the one cycle after the CONTROL write.
            new_target_reg <= start_target;
            new_msg_reg    <= start_msg;
            if (rd_en) begin
                rd_data_reg <= rd_data_next;
            end
        end
    end

    assign newTarget         = new_target_reg;
    assign newMsg            = new_msg_reg;
    assign bus.slaveReadData = rd_data_reg;

endmodule

// File: tb/tb_miner_slave_regs.sv
// ----------------------------------------------------------------------------
// tb_miner_slave_regs
//
// Directed bench for miner_slave_regs: a table of bus writes/reads with
// hand-computed read-back values, followed by hand-written sequences for the
// strobes, busy lockout, sticky status, read/write collision and reset.
// ----------------------------------------------------------------------------
module tb_miner_slave_regs;
    import miner_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    miner_slave_regs_if bus();

    logic                coreBusy;
    logic                coreDone;
    logic                coreFound;
    logic [31:0]         coreNonce;
    logic [TARGET_W-1:0] target;
    logic [MSG_W-1:0]    msg;
    logic                newTarget;
    logic                newMsg;

    miner_slave_regs dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .coreBusy  (coreBusy),
        .coreDone  (coreDone),
        .coreFound (coreFound),
        .coreNonce (coreNonce),
        .target    (target),
        .msg       (msg),
        .newTarget (newTarget),
        .newMsg    (newMsg)
    );

    typedef struct {
        bit          is_wr;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[$];

    int n_vec = 0;
    int n_err = 0;

    function automatic vec_t mk(bit w, logic [4:0] a, logic [31:0] d, logic [31:0] e);
        vec_t v;
        v.is_wr = w;
        v.addr  = a;
        v.data  = d;
        v.exp   = e;
        return v;
    endfunction

    task automatic check32(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", nm, got, exp);
        end else begin
            $display("ok   %s: %08h", nm, got);
        end
    endtask

    task automatic check_w(input string nm, input logic [MSG_W-1:0] got, input logic [MSG_W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end else begin
            $display("ok   %s", nm);
        end
    endtask

    task automatic bus_idle();
        bus.slaveChipSelect = 1'b0;
        bus.slaveWrite      = 1'b0;
        bus.slaveRead       = 1'b0;
    endtask

    // Drive one write cycle; returns on the falling edge after the write edge.
    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.slaveChipSelect = 1'b1;
        bus.slaveWrite      = 1'b1;
        bus.slaveRead       = 1'b0;
        bus.slaveAddr       = a;
        bus.slaveWriteData  = d;
        @(negedge clk);
        bus_idle();
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.slaveChipSelect = 1'b1;
        bus.slaveWrite      = 1'b0;
        bus.slaveRead       = 1'b1;
        bus.slaveAddr       = a;
        @(negedge clk);
        d = bus.slaveReadData;
        bus_idle();
    endtask

    task automatic read_check(input string nm, input logic [4:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check32(nm, d, exp);
    endtask

    // Watchdog: the bench is fixed-length, but never let it hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [TARGET_W-1:0] tgt_exp;
    logic [MSG_W-1:0]    msg_exp;
    logic [31:0]         rd;
    logic                strobe_seen;

    initial begin
        rst                = 1'b1;
        bus.slaveAddr      = '0;
        bus.slaveWriteData = '0;
        bus_idle();
        coreBusy  = 1'b0;
        coreDone  = 1'b0;
        coreFound = 1'b0;
        coreNonce = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // ---------------- reset state ----------------
        check_w("reset_target", {{(MSG_W-TARGET_W){1'b0}}, target}, '0);
        check_w("reset_msg", msg, '0);
        check32("reset_rdata", bus.slaveReadData, 32'h0);

        strobe_seen = 1'b0;
        for (int a = 0; a < 32; a++) begin
            bus_read(5'(a), rd);
            check32($sformatf("reset_rd_addr%0d", a), rd, 32'h0);
            strobe_seen = strobe_seen | newTarget | newMsg;
        end
        check32("reset_strobes_low", {31'b0, strobe_seen}, 32'h0);

        // ---------------- table-driven register map ----------------
        tbl.push_back(mk(1, 5'd23, 32'h0FFF_FFFF, 32'h0));
        for (int a = 22; a >= 16; a--) tbl.push_back(mk(1, 5'(a), 32'hFFFF_FFFF, 32'h0));
        tbl.push_back(mk(0, 5'd23, 32'h0, 32'h0FFF_FFFF));
        tbl.push_back(mk(0, 5'd19, 32'h0, 32'hFFFF_FFFF));
        tbl.push_back(mk(1, 5'd3,  32'h1234_56AB, 32'h0));
        tbl.push_back(mk(0, 5'd3,  32'h0, 32'h1234_5600));
        tbl.push_back(mk(1, 5'd1,  32'hFFFF_FFFF, 32'h0));
        tbl.push_back(mk(0, 5'd1,  32'h0, 32'h0));
        tbl.push_back(mk(1, 5'd2,  32'hFFFF_FFFF, 32'h0));
        tbl.push_back(mk(0, 5'd2,  32'h0, 32'h0));
        tbl.push_back(mk(1, 5'd25, 32'hAAAA_5555, 32'h0));
        tbl.push_back(mk(0, 5'd25, 32'h0, 32'h0));
        tbl.push_back(mk(1, 5'd0,  32'hFFFF_FFF8, 32'h0));
        tbl.push_back(mk(0, 5'd0,  32'h0, 32'h0));
        tbl.push_back(mk(1, 5'd9,  32'hA5A5_0F0F, 32'h0));
        tbl.push_back(mk(0, 5'd9,  32'h0, 32'hA5A5_0F0F));

        foreach (tbl[i]) begin
            if (tbl[i].is_wr) begin
                bus_write(tbl[i].addr, tbl[i].data);
                $display("vec %0d: write addr %0d = %08h", i, tbl[i].addr, tbl[i].data);
            end else begin
                read_check($sformatf("vec%0d_rd_addr%0d", i, tbl[i].addr), tbl[i].addr, tbl[i].exp);
            end
        end

        // ---------------- newTarget strobe ----------------
        tgt_exp = {32'h0FFF_FFFF, {7{32'hFFFF_FFFF}}};
        check_w("target_assembled", {{(MSG_W-TARGET_W){1'b0}}, target}, {{(MSG_W-TARGET_W){1'b0}}, tgt_exp});
        bus_write(ADDR_CTRL, 32'h1);
        check32("newTarget_pulse", {31'b0, newTarget}, 32'h1);
        check32("newMsg_quiet", {31'b0, newMsg}, 32'h0);
        @(negedge clk);
        check32("newTarget_one_cycle", {31'b0, newTarget}, 32'h0);

        // ---------------- message "a" ----------------
        bus_write(5'd15, 32'h6100_0000);
        for (int a = 14; a >= 4; a--) bus_write(5'(a), 32'h0);
        bus_write(5'd3, 32'h0000_00AB);
        bus_write(ADDR_CTRL, 32'h2);
        msg_exp = {8'h61, 400'b0};
        check32("newMsg_pulse", {31'b0, newMsg}, 32'h1);
        check32("newTarget_quiet", {31'b0, newTarget}, 32'h0);
        check_w("msg_a", msg, msg_exp);
        @(negedge clk);
        check32("newMsg_one_cycle", {31'b0, newMsg}, 32'h0);
        read_check("msg_tail_rd", 5'd3, 32'h0);

        // ---------------- busy lockout ----------------
        @(negedge clk);
        coreBusy = 1'b1;
        bus_write(5'd15, 32'hDEAD_BEEF);
        bus_write(5'd16, 32'h0);
        bus_write(ADDR_CTRL, 32'h2);
        check32("busy_no_newMsg", {31'b0, newMsg}, 32'h0);
        bus_write(ADDR_CTRL, 32'h1);
        check32("busy_no_newTarget", {31'b0, newTarget}, 32'h0);
        check_w("busy_msg_kept", msg, msg_exp);
        check_w("busy_target_kept", {{(MSG_W-TARGET_W){1'b0}}, target}, {{(MSG_W-TARGET_W){1'b0}}, tgt_exp});
        read_check("busy_status", ADDR_STATUS, 32'h9);

        // ---------------- sticky status / nonce ----------------
        @(negedge clk);
        coreBusy = 1'b0;
        bus_write(ADDR_CTRL, 32'h4);
        read_check("status_cleared", ADDR_STATUS, 32'h0);

        @(negedge clk);
        coreDone = 1'b1; coreFound = 1'b1; coreNonce = 32'h1234_5678;
        @(negedge clk);
        coreDone = 1'b0; coreFound = 1'b0; coreNonce = 32'h0;
        read_check("found_status", ADDR_STATUS, 32'h6);
        read_check("found_nonce", ADDR_NONCE, 32'h1234_5678);

        // Done without found leaves the captured nonce alone.
        @(negedge clk);
        coreDone = 1'b1; coreFound = 1'b0; coreNonce = 32'h0000_0BAD;
        @(negedge clk);
        coreDone = 1'b0; coreNonce = 32'h0;
        read_check("notfound_nonce_kept", ADDR_NONCE, 32'h1234_5678);

        // coreDone in the same cycle as a clear: set wins.
        @(negedge clk);
        bus.slaveChipSelect = 1'b1; bus.slaveWrite = 1'b1; bus.slaveRead = 1'b0;
        bus.slaveAddr = ADDR_CTRL; bus.slaveWriteData = 32'h4;
        coreDone = 1'b1; coreFound = 1'b1; coreNonce = 32'hCAFE_F00D;
        @(negedge clk);
        bus_idle();
        coreDone = 1'b0; coreFound = 1'b0; coreNonce = 32'h0;
        read_check("done_vs_clear_status", ADDR_STATUS, 32'h6);
        read_check("done_vs_clear_nonce", ADDR_NONCE, 32'hCAFE_F00D);

        // A launched message clears found/done.
        bus_write(ADDR_CTRL, 32'h2);
        read_check("newMsg_clears_status", ADDR_STATUS, 32'h0);

        // ---------------- read/write collision ----------------
        @(negedge clk);
        bus.slaveChipSelect = 1'b1; bus.slaveWrite = 1'b1; bus.slaveRead = 1'b1;
        bus.slaveAddr = 5'd17; bus.slaveWriteData = 32'h1111_2222;
        @(negedge clk);
        rd = bus.slaveReadData;
        bus_idle();
        check32("rw_same_addr_old", rd, 32'hFFFF_FFFF);
        read_check("rw_same_addr_new", 5'd17, 32'h1111_2222);

        // ---------------- reset while strobes are high ----------------
        read_check("pre_reset_nonce", ADDR_NONCE, 32'hCAFE_F00D);
        bus_write(ADDR_CTRL, 32'h3);
        check32("both_strobes_target", {31'b0, newTarget}, 32'h1);
        check32("both_strobes_msg", {31'b0, newMsg}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check32("rst_newTarget", {31'b0, newTarget}, 32'h0);
        check32("rst_newMsg", {31'b0, newMsg}, 32'h0);
        check32("rst_rdata", bus.slaveReadData, 32'h0);
        check_w("rst_target", {{(MSG_W-TARGET_W){1'b0}}, target}, '0);
        check_w("rst_msg", msg, '0);
        read_check("rst_status", ADDR_STATUS, 32'h0);
        read_check("rst_nonce", ADDR_NONCE, 32'h0);

        // Reset on the CONTROL write edge cancels the pending strobes.
        @(negedge clk);
        bus.slaveChipSelect = 1'b1; bus.slaveWrite = 1'b1; bus.slaveRead = 1'b0;
        bus.slaveAddr = ADDR_CTRL; bus.slaveWriteData = 32'h3;
        rst = 1'b1;
        @(negedge clk);
        bus_idle();
        rst = 1'b0;
        check32("rst_cancel_newTarget", {31'b0, newTarget}, 32'h0);
        check32("rst_cancel_newMsg", {31'b0, newMsg}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
